rf_wb_ctrl: RTL and testbench

Writeback-side controller that drives the register file's single write port (A3/WD/RFWr) from two result producers: the single-cycle ALU path and the multi-cycle load path. Load results are buffered in a small FIFO and drained whenever the ALU path is idle. A per-register busy scoreboard tracks issued loads whose results have not yet been written back, and gives decode a hazard flag for its two source operands.

---
 rtl/rf_wb_ctrl_if.sv | 32 +++
 rtl/rf_wb_ctrl.sv | 94 +++++++++
 tb/tb_rf_wb_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rf_wb_ctrl_if.sv
// Writeback bus bundle: ALU result, load result, load issue/operand query in;
// scoreboard state and register-file write port out.
interface rf_wb_ctrl_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_wd;
    logic        mem_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  src_a1;
    logic [4:0]  src_a2;
    logic        hazard;
    logic [31:0] busy;
    logic        rf_wr;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    modport master (
        output alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd,
               iss_valid, iss_rd, src_a1, src_a2,
        input  mem_ready, hazard, busy, rf_wr, rf_a3, rf_wd
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd,
               iss_valid, iss_rd, src_a1, src_a2,
        output mem_ready, hazard, busy, rf_wr, rf_a3, rf_wd
    );
endinterface

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: ALU results take the write port first,
// buffered load results drain when the ALU is idle; busy scoreboard for loads.
module rf_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic         clk,
    input logic         rst_n,
    rf_wb_ctrl_if.slave bus
);
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ld_ent_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    ld_ent_t     r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [31:0]   r_busy;
    logic          r_wr;
    logic [4:0]    r_a3;
    logic [31:0]   r_wd;

    logic        w_ready;
    logic        w_push;
    logic        w_pop;
    ld_ent_t     w_head;
    logic [31:0] w_busy_nxt;

    // Readiness and pop eligibility come from the registered count only, so a
    // same-cycle push is never popped and a same-cycle pop never frees a slot.
    assign w_ready = (r_cnt != FULL);
    assign w_push  = bus.mem_valid && w_ready;
    assign w_pop   = !bus.alu_valid && (r_cnt != '0);
    assign w_head  = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= '{rd: bus.mem_rd, wd: bus.mem_wd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    // A new issue to the same register outranks the clear from a draining load.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop)         w_busy_nxt[w_head.rd]    = 1'b0;
        if (bus.iss_valid) w_busy_nxt[bus.iss_rd]   = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= 1'b0;
            r_a3 <= '0;
            r_wd <= '0;
        end else if (bus.alu_valid) begin
            r_wr <= (bus.alu_rd != 5'd0);
            r_a3 <= bus.alu_rd;
            r_wd <= bus.alu_wd;
        end else if (w_pop) begin
            r_wr <= (w_head.rd != 5'd0);
            r_a3 <= w_head.rd;
            r_wd <= w_head.wd;
        end else begin
            r_wr <= 1'b0;
        end
    end

    assign bus.mem_ready = w_ready;
    assign bus.busy      = r_busy;
    assign bus.hazard    = r_busy[bus.src_a1] | r_busy[bus.src_a2];
    assign bus.rf_wr     = r_wr;
    assign bus.rf_a3     = r_a3;
    assign bus.rf_wd     = r_wd;
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Scoreboard bench for rf_wb_ctrl: directed scenarios plus random traffic
// against a queue-based model of the writeback rules.
module tb_rf_wb_ctrl;
    localparam int DEPTH = 4;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] wd;
    } wr_exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ld_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    wr_exp_t     exp_q[$];
    ld_t         ld_q[$];
    logic [31:0] m_busy = '0;

    rf_wb_ctrl_if bus();

    rf_wb_ctrl #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected write-port state per clock, popped after each edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                chk("rf_wr_unexpected", {31'd0, bus.rf_wr}, 32'd0);
            end else begin
                wr_exp_t e;
                e = exp_q.pop_front();
                chk("rf_wr", {31'd0, bus.rf_wr}, {31'd0, e.wr});
                if (e.wr && bus.rf_wr) begin
                    chk("rf_a3", {27'd0, bus.rf_a3}, {27'd0, e.rd});
                    chk("rf_wd", bus.rf_wd, e.wd);
                end
            end
        end
    end

    // Drive one cycle at a negedge, check registered/comb outputs against the
    // model, apply the writeback rules to the model, then advance to next negedge.
    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mwd,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] a1, input logic [4:0] a2);
        wr_exp_t e;
        ld_t     h;
        logic    rdy;
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_wd = awd;
        bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_wd = mwd;
        bus.iss_valid = iv; bus.iss_rd = ird;
        bus.src_a1 = a1; bus.src_a2 = a2;
        #1;
        rdy = (ld_q.size() != DEPTH);
        chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, rdy});
        chk("busy", bus.busy, m_busy);
        chk("hazard", {31'd0, bus.hazard}, {31'd0, (m_busy[a1] | m_busy[a2])});
        e.wr = 1'b0; e.rd = '0; e.wd = '0;
        if (av) begin
            e.wr = (ard != 0); e.rd = ard; e.wd = awd;
        end else if (ld_q.size() > 0) begin
            h = ld_q.pop_front();
            m_busy[h.rd] = 1'b0;
            e.wr = (h.rd != 0); e.rd = h.rd; e.wd = h.wd;
        end
        exp_q.push_back(e);
        if (mv && rdy) ld_q.push_back('{rd: mrd, wd: mwd});
        if (iv && ird != 0) m_busy[ird] = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rf_wr", {31'd0, bus.rf_wr}, 32'd0);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("rst_hazard", {31'd0, bus.hazard}, 32'd0);
        exp_q.delete();
        ld_q.delete();
        m_busy = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_wd = 0;
        bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_wd = 0;
        bus.iss_valid = 0; bus.iss_rd = 0; bus.src_a1 = 0; bus.src_a2 = 0;
        @(negedge clk);
        chk("init_rf_a3", {27'd0, bus.rf_a3}, 32'd0);
        chk("init_rf_wd", bus.rf_wd, 32'd0);
        do_reset();

        // ALU write, then ALU write to r0 (suppressed)
        cyc(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'h5678, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // ALU priority over a buffered load to r7
        cyc(1, 1, 32'h11, 1, 7, 32'hAAAA, 1, 7, 7, 0);
        cyc(1, 2, 32'h22, 0, 0, 0, 0, 0, 7, 0);
        cyc(1, 3, 32'h33, 0, 0, 0, 0, 0, 7, 0);
        idle(3);

        // Fill to full under continuous ALU traffic, 5th offer refused
        for (int i = 0; i < 5; i++)
            cyc(1, 5'(20 + i), 32'(i), 1, 5'(1 + i), 32'hB000 + 32'(i), 0, 0, 0, 0);
        chk("full_not_ready", {31'd0, bus.mem_ready}, 32'd0);
        cyc(0, 0, 0, 1, 30, 32'hDEAD, 0, 0, 0, 0);
        idle(6);

        // Scoreboard: issue r9, hazard until its load pops
        cyc(1, 4, 32'h44, 0, 0, 0, 1, 9, 0, 0);
        chk("sb_busy9", {31'd0, bus.busy[9]}, 32'd1);
        cyc(1, 4, 32'h45, 1, 9, 32'h9999, 0, 0, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        chk("sb_hazard_clr", {31'd0, bus.hazard}, 32'd0);
        idle(2);

        // Set/clear collision on r12: set wins
        cyc(1, 6, 32'h66, 1, 12, 32'hC12, 1, 12, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 12, 0, 12);
        chk("collide_busy12", {31'd0, bus.busy[12]}, 32'd1);
        idle(2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] ard, mrd, ird;
            ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            ird = 5'($urandom);
            cyc(1'($urandom_range(0, 99) < 45), ard, $urandom,
                1'($urandom_range(0, 1)), mrd, $urandom,
                1'($urandom_range(0, 99) < 30), ird,
                5'($urandom), 5'($urandom));
        end
        idle(6);

        // Reset mid-stream with three buffered loads
        for (int i = 0; i < 3; i++)
            cyc(1, 5'(8 + i), 32'(i), 1, 5'(13 + i), 32'hF0 + 32'(i), 1, 5'(13 + i), 0, 0);
        do_reset();
        idle(6);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
